// File: rtl/f1_start_ctrl.sv
// F1-style start-light controller: eight-step light bar, random hold before lights-out,
// then a reaction timer stopped by the driver button. Early presses are flagged as jump starts.
module f1_start_ctrl #(
    parameter int TICK_DIV = 16,
    parameter int RT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            btn,
    output logic [7:0]      lights,
    output logic            busy,
    output logic            react_valid,
    output logic [RT_W-1:0] react_time,
    output logic            jump_start
);
    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {IDLE, LIGHT, HOLD, TIMING, DONE, JUMP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [6:0]        lfsr;
    logic [7:0]        hold_cnt;
    logic [RT_W-1:0]   rcnt;
    logic              btn_q;
    logic              tick;
    logic              btn_edge;

    assign tick     = (div == DIV_W'(TICK_DIV - 1));
    assign btn_edge = btn & ~btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div         <= '0;
            lfsr        <= 7'h01;
            hold_cnt    <= '0;
            rcnt        <= '0;
            btn_q       <= 1'b0;
            lights      <= '0;
            busy        <= 1'b0;
            react_valid <= 1'b0;
            react_time  <= '0;
            jump_start  <= 1'b0;
        end else begin
            btn_q       <= btn;
            lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            react_valid <= 1'b0;
            div         <= tick ? '0 : div + DIV_W'(1);
            case (state)
                IDLE, DONE, JUMP: begin
                    // Trigger wins over any coincident button edge here.
                    div <= '0;
                    if (trigger) begin
                        state      <= LIGHT;
                        lights     <= '0;
                        jump_start <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                LIGHT: begin
                    if (btn_edge) begin
                        state      <= JUMP;
                        lights     <= '0;
                        jump_start <= 1'b1;
                        busy       <= 1'b0;
                    end else if (tick) begin
                        lights <= {lights[6:0], 1'b1};
                        if (lights[6]) begin
                            state    <= HOLD;
                            div      <= '0;
                            hold_cnt <= {1'b0, lfsr} + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (btn_edge) begin
                        state      <= JUMP;
                        lights     <= '0;
                        jump_start <= 1'b1;
                        busy       <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == 8'd1) begin
                            state    <= TIMING;
                            lights   <= '0;
                            rcnt     <= '0;
                            div      <= '0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                end
                TIMING: begin
                    if (btn_edge) begin
                        state       <= DONE;
                        react_time  <= rcnt;
                        react_valid <= 1'b1;
                        busy        <= 1'b0;
                    end else if (~&rcnt) begin
                        rcnt <= rcnt + RT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    lights <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed bench for f1_start_ctrl with TICK_DIV=4: light sequence, reaction capture,
// jump starts at the light/hold boundaries, counter saturation and mid-sequence reset.
module tb_f1_start_ctrl;
    localparam int TICK_DIV = 4;
    localparam int RT_W     = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            trigger;
    logic            btn;
    logic [7:0]      lights;
    logic            busy;
    logic            react_valid;
    logic [RT_W-1:0] react_time;
    logic            jump_start;

    int n_chk  = 0;
    int n_fail = 0;
    int hold_len;
    int n;

    f1_start_ctrl #(.TICK_DIV(TICK_DIV), .RT_W(RT_W)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .btn(btn),
        .lights(lights), .busy(busy), .react_valid(react_valid),
        .react_time(react_time), .jump_start(jump_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lights(input logic [7:0] v, input int max, input string tag, output int cnt);
        cnt = 0;
        while (lights !== v && cnt < max) begin
            step();
            cnt++;
        end
        chk(tag, {24'h0, lights}, {24'h0, v});
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b0; btn = 1'b0;
        repeat (3) step();
        chk("rst_lights", {24'h0, lights}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, react_valid}, 32'h0);
        chk("rst_rtime", {16'h0, react_time}, 32'h0);
        chk("rst_jump", {31'h0, jump_start}, 32'h0);

        // Run 1: full sequence, hold length measured for the replay in run 2.
        rst = 1'b0;
        repeat (2) step();
        pulse_trigger();
        chk("start_busy", {31'h0, busy}, 32'h1);
        repeat (3) step();
        chk("light_pre", {24'h0, lights}, 32'h0);
        step();
        chk("light_1", {24'h0, lights}, 32'h01);
        for (int k = 2; k <= 8; k++) begin
            repeat (TICK_DIV) step();
            chk("light_k", {24'h0, lights}, (32'h1 << k) - 32'h1);
        end
        chk("hold_busy", {31'h0, busy}, 32'h1);
        wait_lights(8'h00, 600, "hold_end", hold_len);
        chk("hold_range", {31'h0, (hold_len >= 4 && hold_len <= 512 && hold_len % 4 == 0)}, 32'h1);
        chk("timing_busy", {31'h0, busy}, 32'h1);

        repeat (10) step();
        btn = 1'b1;
        step();
        chk("react_valid", {31'h0, react_valid}, 32'h1);
        chk("react_time10", {16'h0, react_time}, 32'd10);
        chk("done_busy", {31'h0, busy}, 32'h0);
        step();
        chk("react_pulse1", {31'h0, react_valid}, 32'h0);
        btn = 1'b0;
        step();
        btn = 1'b1;
        step();
        chk("done_btn_valid", {31'h0, react_valid}, 32'h0);
        chk("done_btn_rtime", {16'h0, react_time}, 32'd10);
        btn = 1'b0;
        step();

        // Jump start while lights=07.
        pulse_trigger();
        chk("retrig_jump", {31'h0, jump_start}, 32'h0);
        chk("retrig_rtime", {16'h0, react_time}, 32'd10);
        repeat (12) step();
        chk("light_07", {24'h0, lights}, 32'h07);
        btn = 1'b1;
        step();
        chk("j07_lights", {24'h0, lights}, 32'h0);
        chk("j07_jump", {31'h0, jump_start}, 32'h1);
        chk("j07_valid", {31'h0, react_valid}, 32'h0);
        chk("j07_rtime", {16'h0, react_time}, 32'd10);
        chk("j07_busy", {31'h0, busy}, 32'h0);
        btn = 1'b0;
        step();

        // Trigger and button edge together in JUMP: trigger accepted.
        trigger = 1'b1; btn = 1'b1;
        step();
        trigger = 1'b0;
        chk("coin_busy", {31'h0, busy}, 32'h1);
        chk("coin_jump", {31'h0, jump_start}, 32'h0);
        btn = 1'b0;
        step();
        pulse_trigger();
        repeat (2) step();
        chk("ign_trig_l1", {24'h0, lights}, 32'h01);
        repeat (24) step();
        chk("light_7f", {24'h0, lights}, 32'h7F);
        repeat (3) step();
        btn = 1'b1;
        step();
        chk("jlast_lights", {24'h0, lights}, 32'h0);
        chk("jlast_jump", {31'h0, jump_start}, 32'h1);
        chk("jlast_busy", {31'h0, busy}, 32'h0);
        btn = 1'b0;
        step();

        // Reaction counter saturation.
        pulse_trigger();
        chk("sat_jump_clr", {31'h0, jump_start}, 32'h0);
        wait_lights(8'hFF, 40, "sat_ff", n);
        wait_lights(8'h00, 600, "sat_timing", n);
        repeat (65541) step();
        chk("sat_busy", {31'h0, busy}, 32'h1);
        btn = 1'b1;
        step();
        chk("sat_valid", {31'h0, react_valid}, 32'h1);
        chk("sat_rtime", {16'h0, react_time}, 32'hFFFF);
        btn = 1'b0;
        step();

        // Reset during HOLD aborts immediately.
        pulse_trigger();
        wait_lights(8'hFF, 40, "r_ff", n);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("arst_lights", {24'h0, lights}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_rtime", {16'h0, react_time}, 32'h0);
        chk("arst_valid", {31'h0, react_valid}, 32'h0);
        chk("arst_jump", {31'h0, jump_start}, 32'h0);
        repeat (2) step();
        // Same timing from reset release as run 1, so the hold length repeats.
        rst = 1'b0;
        repeat (2) step();
        pulse_trigger();
        repeat (4) step();
        chk("r_light_1", {24'h0, lights}, 32'h01);
        repeat (28) step();
        chk("r_light_ff", {24'h0, lights}, 32'hFF);
        repeat (hold_len - 1) step();
        chk("hold_last", {24'h0, lights}, 32'hFF);
        btn = 1'b1;
        step();
        chk("jhold_lights", {24'h0, lights}, 32'h0);
        chk("jhold_jump", {31'h0, jump_start}, 32'h1);
        chk("jhold_valid", {31'h0, react_valid}, 32'h0);
        chk("jhold_busy", {31'h0, busy}, 32'h0);
        btn = 1'b0;
        step();
        chk("jhold_valid2", {31'h0, react_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
